// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU issuer and its response queue.
package alu_pkg;

  localparam int unsigned OPND_W  = 4;
  localparam int unsigned RES_W   = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned QCNT_W  = 2;
  localparam int unsigned Q_DEPTH = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_MUL = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             err;
  } rsp_entry_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Two-entry response FIFO; the head entry is always held in ent0_q.
module alu_rsp_fifo
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  rsp_entry_t        din_i,
  input  logic              pop_i,
  output rsp_entry_t        head_o,
  output logic [QCNT_W-1:0] count_o
);

  rsp_entry_t        ent0_q, ent0_d;
  rsp_entry_t        ent1_q, ent1_d;
  logic [QCNT_W-1:0] cnt_q, cnt_d;
  logic              pop_c;

  // Next-state of the storage: pop shifts entry 1 forward, push fills the first free slot.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    pop_c  = pop_i && (cnt_q != '0);
    unique case ({push_i, pop_c})
      2'b10: begin
        if (cnt_q == '0) ent0_d = din_i;
        else             ent1_d = din_i;
        cnt_d = cnt_q + QCNT_W'(1);
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - QCNT_W'(1);
      end
      2'b11: begin
        if (cnt_q == QCNT_W'(1)) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_op_issuer.sv
// Command-side initiator for the 4-bit ALU: issues one operation at a time,
// captures the result after ALU_LATENCY and returns it through a 2-entry queue.
// Optional feature macro: ALU_ISSUER_DIVZERO_EN (divide-by-zero short-circuit).
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  cur_tag_q;
  logic [OPND_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [QCNT_W-1:0] q_count;
  rsp_entry_t        head;
  rsp_entry_t        push_entry;
  logic              push_c;
  logic              accept_c;
  logic              divzero_c;
  logic              dz_pend_q;
  logic [QCNT_W:0]   occ_c;

  assign accept_c = cmd_valid && cmd_ready;

`ifdef ALU_ISSUER_DIVZERO_EN
  assign divzero_c = (cmd_op == OP_DIV) && (cmd_b == '0);

  // A short-circuited div pushes its error response on the edge after accept.
  always_ff @(posedge clk) begin
    if (rst) dz_pend_q <= 1'b0;
    else     dz_pend_q <= accept_c && divzero_c;
  end
`else
  assign divzero_c = 1'b0;
  assign dz_pend_q = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: leave IDLE on an issued command, return once the counter has expired.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_c && !divzero_c) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)            state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready counts a pending error push as occupied; capture pushes the sampled result.
  always_comb begin
    cmd_ready  = 1'b0;
    push_c     = 1'b0;
    push_entry = '0;
    occ_c      = (QCNT_W+1)'(q_count) + (QCNT_W+1)'(dz_pend_q);
    unique case (state_q)
      ST_IDLE: cmd_ready = !rst && (occ_c < (QCNT_W+1)'(Q_DEPTH));
      ST_WAIT: begin
        if (cnt_q == '0) begin
          push_c     = 1'b1;
          push_entry = '{data: alu_result, tag: cur_tag_q,
                         zero: (alu_result == '0), err: 1'b0};
        end
      end
      default: ;
    endcase
    if (dz_pend_q) begin
      push_c     = 1'b1;
      push_entry = '{data: 8'hFF, tag: cur_tag_q, zero: 1'b0, err: 1'b1};
    end
  end

  // Issue datapath: operand registers, wait counter and tag counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      cnt_q     <= '0;
      tag_q     <= '0;
      cur_tag_q <= '0;
    end else if (accept_c) begin
      tag_q     <= tag_q + TAG_W'(1);
      cur_tag_q <= tag_q;
      if (!divzero_c) begin
        alu_a_q  <= cmd_a;
        alu_b_q  <= cmd_b;
        alu_op_q <= cmd_op;
        cnt_q    <= CNT_W'(ALU_LATENCY);
      end
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  alu_rsp_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (push_entry),
    .pop_i   (rsp_ready),
    .head_o  (head),
    .count_o (q_count)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = (q_count != '0);
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;
  assign rsp_zero  = head.zero;
  assign rsp_err   = head.err;

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Command-side initiator for the 4-bit ALU. It accepts packed operation requests over a valid/ready port and drives the ALU's operand and opcode inputs. After a fixed ALU latency it captures the 8-bit result and returns it, with a tag and flags, through a 2-entry response queue with valid/ready backpressure. It sits between the host/test logic and the ALU, and only one operation is in flight at a time.

## Interface
- `ALU_LATENCY`, default 1: edges between ALU inputs becoming stable and the result being valid; legal range 1–15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: request accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_op` in 2: opcode, 00 add, 01 mul, 10 sub, 11 div.
- `alu_a` out 4: operand A to ALU (registered).
- `alu_b` out 4: operand B to ALU (registered).
- `alu_op` out 2: opcode to ALU (registered).
- `alu_result` in 8: ALU result.
- `rsp_valid` out 1: response queue non-empty.
- `rsp_ready` in 1: response popped on an edge where `rsp_valid & rsp_ready`.
- `rsp_data` out 8: captured result.
- `rsp_tag` out 2: sequence tag of the command that produced the response.
- `rsp_zero` out 1: `rsp_data == 0`.
- `rsp_err` out 1: divide-by-zero flag (see Configuration).

## Operation
- FSM states:
  - IDLE: `cmd_ready = (q_count < 2)`. On accept, register `cmd_a/b/op` into `alu_a/b/op`, load the wait counter with `ALU_LATENCY`, go to WAIT.
  - WAIT: counter decrements each edge. On the edge where it reaches 0, push `{alu_result, tag, zero, err=0}` into the queue and go to IDLE.
- `cmd_ready` is 0 in WAIT.
- Tag counter: 2-bit, increments on every accept, wraps 3→0. Each response carries the tag value at its accept.
- Queue:
  - 2 entries, FIFO order. Push and pop on the same edge are both performed.
  - A push can never overflow, because accept requires `q_count < 2` and only one push is outstanding.
- `alu_a/b/op` hold their last issued values while idle.
- The issuer does not interpret `alu_result`. Sub and div results are passed through as the ALU's modular 8-bit values.
- Reset mid-operation: FSM returns to IDLE, queue is emptied, tag is cleared, and the in-flight result is discarded.
- Reset values: `cmd_ready = 0` during reset; `alu_a/b/op`, `rsp_valid`, `rsp_data`, `rsp_tag`, `rsp_zero`, `rsp_err` are all 0.

## Timing
- Accept on edge T.
  - `alu_*` valid from T+1.
  - Result sampled on edge T+1+`ALU_LATENCY`.
  - `rsp_valid` high after that edge, provided the queue was empty.
- `cmd_ready` is high again the cycle after the capture edge. Throughput is one command per `ALU_LATENCY`+2 cycles.
- `rsp_*` come from the queue head register with no combinational path from `alu_result`.
- `cmd_ready` depends only on state and `q_count`, never on `cmd_valid`.

## Configuration
- `ALU_ISSUER_DIVZERO_EN` defined: an accepted div with `cmd_b == 0` is not issued.
  - `alu_*` are unchanged.
  - Response `{8'hFF, tag, zero=0, err=1}` is pushed on edge T+1.
  - FSM stays IDLE.
- Macro undefined: div-by-zero is issued like any other op, `rsp_err` is tied to 0, and no detection logic is built.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD`, `OP_MUL`, `OP_SUB`, `OP_DIV`;
  - FSM state encoding;
  - response entry struct `{data[7:0], tag[1:0], zero, err}`.
- Sub-module `alu_rsp_fifo`: 2-entry synchronous FIFO of response entries with push, pop and count. Same `clk`/`rst`.

## Test plan
- Reset: hold `rst` for 2 cycles → every output is 0. `cmd_ready = 1` on the first cycle after release.
- Add: `ALU_LATENCY=1`, `rsp_ready=1`, accept `a=3, b=5, op=00` with the ALU model returning 8'h08 → `alu_a=3`, `alu_b=5` at T+1. `rsp_valid` after edge T+2 with `rsp_data=8'h08`, `rsp_tag=0`, `rsp_zero=0`.
- Sub wrap: `a=2, b=5, op=10`, model returns 8'hFD → `rsp_data=8'hFD`, `rsp_zero=0`. With `a=b=4` the model returns 8'h00 → `rsp_zero=1`.
- Backpressure: `rsp_ready=0`, present 3 back-to-back commands → 2 responses queued (tags 0, 1) and `cmd_ready` stays 0. After one pop, the third is accepted with tag 2. Responses drain in order 0, 1, 2.
- Div-by-zero: `a=7, b=0, op=11`.
  - With the macro: `alu_*` unchanged, `rsp_data=8'hFF`, `rsp_err=1`, `rsp_valid` after edge T+1.
  - Without the macro: the command is issued and `rsp_err=0`.
- Reset in WAIT: `ALU_LATENCY=4`, assert `rst` 2 edges after accept → `rsp_valid` never rises. The next accepted command carries `rsp_tag=0`.
